// File: rtl/prga_decrypt.sv
// RC4 pseudo-random generation stage: walks i/j over the S-box RAM, swaps
// S[i]/S[j], and XORs the keystream byte into each encrypted ROM byte.
module prga_decrypt #(
  parameter int MSG_LEN = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       finished,
  output logic [7:0] s_address,
  input  logic [7:0] s_data_in,
  output logic [7:0] s_data_out,
  output logic       s_wren,
  output logic [4:0] rom_address,
  input  logic [7:0] rom_data,
  output logic [4:0] dec_address,
  output logic [7:0] dec_data,
  output logic       dec_wren
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] RD_SI    = 4'd1;
  localparam logic [3:0] WAIT_SI  = 4'd2;
  localparam logic [3:0] LATCH_SI = 4'd3;
  localparam logic [3:0] WAIT_SJ  = 4'd4;
  localparam logic [3:0] LATCH_SJ = 4'd5;
  localparam logic [3:0] WR_I     = 4'd6;
  localparam logic [3:0] WR_J     = 4'd7;
  localparam logic [3:0] RD_F     = 4'd8;
  localparam logic [3:0] WAIT_F   = 4'd9;
  localparam logic [3:0] LATCH_F  = 4'd10;
  localparam logic [3:0] WR_DEC   = 4'd11;
  localparam logic [3:0] NEXT     = 4'd12;
  localparam logic [3:0] DONE     = 4'd13;

  localparam logic [4:0] LAST_K = 5'(MSG_LEN - 1);

  logic [3:0] state_q, state_d;
  logic [7:0] i_q, i_d;
  logic [7:0] j_q, j_d;
  logic [4:0] k_q, k_d;
  logic [7:0] si_q, si_d;
  logic [7:0] sj_q, sj_d;
  logic [7:0] f_q, f_d;
  logic [7:0] enc_q, enc_d;
  logic [7:0] idx_sum;

  // Index of the keystream byte; 8-bit add wraps mod 256 by construction.
  assign idx_sum = si_q + sj_q;

  // NOTE: every output and next-state variable gets a default at the top of
  // the block so no path leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    si_d        = si_q;
    sj_d        = sj_q;
    f_d         = f_q;
    enc_d       = enc_q;
    finished    = 1'b0;
    s_address   = 8'd0;
    s_data_out  = 8'd0;
    s_wren      = 1'b0;
    rom_address = k_q;
    dec_address = k_q;
    dec_data    = 8'd0;
    dec_wren    = 1'b0;

    case (state_q)
      IDLE: begin
        i_d = 8'd0;
        j_d = 8'd0;
        k_d = 5'd0;
        if (start) begin
          i_d     = 8'd1;
          state_d = RD_SI;
        end
      end
      RD_SI: begin
        s_address = i_q;
        state_d   = WAIT_SI;
      end
      WAIT_SI: begin
        s_address = i_q;
        state_d   = LATCH_SI;
      end
      LATCH_SI: begin
        si_d      = s_data_in;
        j_d       = j_q + s_data_in;
        s_address = j_d;
        state_d   = WAIT_SJ;
      end
      WAIT_SJ: begin
        s_address = j_q;
        state_d   = LATCH_SJ;
      end
      LATCH_SJ: begin
        s_address = j_q;
        sj_d      = s_data_in;
        state_d   = WR_I;
      end
      // When i == j both writes land on one address and S is left intact.
      WR_I: begin
        s_wren     = 1'b1;
        s_address  = i_q;
        s_data_out = sj_q;
        state_d    = WR_J;
      end
      WR_J: begin
        s_wren     = 1'b1;
        s_address  = j_q;
        s_data_out = si_q;
        state_d    = RD_F;
      end
      RD_F: begin
        s_address = idx_sum;
        state_d   = WAIT_F;
      end
      WAIT_F: begin
        s_address = idx_sum;
        state_d   = LATCH_F;
      end
      LATCH_F: begin
        s_address = idx_sum;
        f_d       = s_data_in;
        enc_d     = rom_data;
        state_d   = WR_DEC;
      end
      WR_DEC: begin
        dec_wren = 1'b1;
        dec_data = f_q ^ enc_q;
        state_d  = NEXT;
      end
      NEXT: begin
        if (k_q == LAST_K) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + 5'd1;
          i_d     = i_q + 8'd1;
          state_d = RD_SI;
        end
      end
      DONE: begin
        finished = 1'b1;
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // its _d value from the same pre-edge snapshot.
  // NOTE: all datapath registers are reset, so the combinational outputs
  // decoded from them collapse to zero the moment reset rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      k_q     <= 5'd0;
      si_q    <= 8'd0;
      sj_q    <= 8'd0;
      f_q     <= 8'd0;
      enc_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      f_q     <= f_d;
      enc_q   <= enc_d;
    end
  end

endmodule

// File: tb/tb_prga_decrypt.sv
// Bench for prga_decrypt: two-stage synchronous RAM/ROM models around the DUT
// and an array-based RC4 PRGA reference model.
module tb_prga_decrypt;

  localparam int MSG_LEN = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       finished;
  logic [7:0] s_address, s_data_in, s_data_out;
  logic       s_wren;
  logic [4:0] rom_address;
  logic [7:0] rom_data;
  logic [4:0] dec_address;
  logic [7:0] dec_data;
  logic       dec_wren;

  prga_decrypt #(.MSG_LEN(MSG_LEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .finished   (finished),
    .s_address  (s_address),
    .s_data_in  (s_data_in),
    .s_data_out (s_data_out),
    .s_wren     (s_wren),
    .rom_address(rom_address),
    .rom_data   (rom_data),
    .dec_address(dec_address),
    .dec_data   (dec_data),
    .dec_wren   (dec_wren)
  );

  always #5 clk = ~clk;

  // Memory models: address registered, then data registered -> read data for
  // an address driven in cycle N is valid in cycle N+2.
  logic [7:0] s_mem    [256];
  logic [7:0] load_buf [256];
  logic       load_req = 1'b0;
  logic [7:0] s_addr_r = 8'd0, s_rd = 8'd0;
  logic [7:0] rom_mem  [32];
  logic [4:0] rom_addr_r = 5'd0;
  logic [7:0] rom_rd = 8'd0;
  logic [7:0] dec_mem  [32];
  int         dec_log  [1024];
  int         dec_cnt = 0, swren_cnt = 0, overlap_cnt = 0;
  logic [7:0] snap2 = 8'd0, snap3 = 8'd0;

  assign s_data_in = s_rd;
  assign rom_data  = rom_rd;

  always @(posedge clk) begin
    s_addr_r   <= s_address;
    s_rd       <= s_mem[s_addr_r];
    rom_addr_r <= rom_address;
    rom_rd     <= rom_mem[rom_addr_r];
    if (load_req) begin
      for (int x = 0; x < 256; x++) s_mem[x] <= load_buf[x];
    end else if (s_wren) begin
      s_mem[s_address] <= s_data_out;
    end
    if (s_wren) swren_cnt <= swren_cnt + 1;
    if (dec_wren) begin
      dec_mem[dec_address] <= dec_data;
      if (dec_cnt < 1024) dec_log[dec_cnt] <= int'(dec_address);
      dec_cnt <= dec_cnt + 1;
      if (dec_address == 5'd1) begin
        snap2 <= s_mem[2];
        snap3 <= s_mem[3];
      end
    end
    if (s_wren && dec_wren) overlap_cnt <= overlap_cnt + 1;
  end

  // Reference model state
  int ms [256];
  int exp_dec [32];
  int passed = 0, total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic ksa_fill();
    int key [3];
    int j = 0;
    int t;
    for (int x = 0; x < 3; x++) key[x] = int'($urandom_range(0, 255));
    for (int x = 0; x < 256; x++) ms[x] = x;
    for (int x = 0; x < 256; x++) begin
      j = (j + ms[x] + key[x % 3]) % 256;
      t = ms[x]; ms[x] = ms[j]; ms[j] = t;
    end
  endtask

  task automatic rom_random();
    for (int n = 0; n < 32; n++) rom_mem[n] = 8'($urandom_range(0, 255));
  endtask

  task automatic load_s();
    for (int x = 0; x < 256; x++) load_buf[x] = 8'(ms[x]);
    @(negedge clk) load_req = 1'b1;
    @(negedge clk) load_req = 1'b0;
  endtask

  // Plain RC4 PRGA over the model S, restarting at i=j=0.
  task automatic model_pass();
    int i = 0, j = 0, t;
    for (int n = 0; n < MSG_LEN; n++) begin
      i = (i + 1) % 256;
      j = (j + ms[i]) % 256;
      t = ms[i]; ms[i] = ms[j]; ms[j] = t;
      exp_dec[n] = ms[(ms[i] + ms[j]) % 256] ^ int'(rom_mem[n]);
    end
  endtask

  task automatic run_pass(input string tag);
    int base = dec_cnt;
    int sw_base = swren_cnt;
    int cyc = 0;
    int bad_addr = 0;
    int bad_s = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    while (cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (finished) break;
    end
    check({tag, " cycles"}, cyc, 12 * MSG_LEN);
    check({tag, " dec pulses"}, dec_cnt - base, MSG_LEN);
    check({tag, " s writes"}, swren_cnt - sw_base, 2 * MSG_LEN);
    for (int n = 0; n < MSG_LEN; n++) if (dec_log[base + n] != n) bad_addr++;
    check({tag, " dec addr order errors"}, bad_addr, 0);
    for (int n = 0; n < MSG_LEN; n++)
      check($sformatf("%s dec[%0d]", tag, n), dec_mem[n], exp_dec[n]);
    for (int x = 0; x < 256; x++) if (int'(s_mem[x]) != ms[x]) bad_s++;
    check({tag, " final S errors"}, bad_s, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base, sw_base, cyc, found, errs;

    // Reset state
    reset = 1'b1;
    start = 1'b0;
    for (int x = 0; x < 256; x++) s_mem[x] = 8'd0;
    for (int n = 0; n < 32; n++) begin
      rom_mem[n] = 8'd0;
      dec_mem[n] = 8'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs",
          {finished, s_address, s_data_out, s_wren, rom_address, dec_address, dec_data, dec_wren}, 0);
    @(negedge clk) reset = 1'b0;
    base = dec_cnt;
    sw_base = swren_cnt;
    repeat (6) @(posedge clk);
    #1;
    check("idle without start writes", (dec_cnt - base) + (swren_cnt - sw_base), 0);
    check("idle finished", finished, 0);

    // Identity S, zero ciphertext; full pass with start held high
    for (int x = 0; x < 256; x++) ms[x] = x;
    load_s();
    model_pass();
    run_pass("ident");
    check("ident dec[0] const", dec_mem[0], 8'h02);
    check("ident dec[1] const", dec_mem[1], 8'h05);
    check("ident S[2] after byte1", snap2, 8'h03);
    check("ident S[3] after byte1", snap3, 8'h02);

    // Start held high after completion must not restart
    base = dec_cnt;
    sw_base = swren_cnt;
    repeat (20) @(posedge clk);
    #1;
    check("done holds finished", finished, 1);
    check("no writes while held", (dec_cnt - base) + (swren_cnt - sw_base), 0);

    // Restart 1->0->1: second pass continues from the permuted S
    @(negedge clk) start = 1'b0;
    @(posedge clk); #1;
    check("finished drops", finished, 0);
    rom_random();
    model_pass();
    run_pass("restart");

    // Reset during WR_J of byte 5
    @(negedge clk) start = 1'b0;
    ksa_fill();
    rom_random();
    load_s();
    base = dec_cnt;
    sw_base = swren_cnt;
    @(negedge clk) start = 1'b1;
    found = 0;
    cyc = 0;
    while (cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if ((swren_cnt - sw_base == 11) && s_wren) begin
        found = 1;
        break;
      end
    end
    check("located WR_J of byte 5", found, 1);
    reset = 1'b1;
    start = 1'b0;
    #1;
    check("async reset outputs",
          {finished, s_address, s_data_out, s_wren, rom_address, dec_address, dec_data, dec_wren}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("s writes after reset", swren_cnt - sw_base, 11);
    check("dec writes after reset", dec_cnt - base, 5);
    check("finished after reset", finished, 0);

    // Fresh pass from k=0 on a reloaded random S
    ksa_fill();
    rom_random();
    load_s();
    model_pass();
    run_pass("post-reset");

    // Wrap: S all 0xFF -> keystream is always 0xFF
    @(negedge clk) start = 1'b0;
    for (int x = 0; x < 256; x++) ms[x] = 255;
    rom_random();
    load_s();
    model_pass();
    run_pass("wrap");
    errs = 0;
    for (int n = 0; n < MSG_LEN; n++) if (dec_mem[n] != (rom_mem[n] ^ 8'hFF)) errs++;
    check("wrap enc^FF errors", errs, 0);

    // Random key-scheduled S with random ciphertext
    @(negedge clk) start = 1'b0;
    ksa_fill();
    rom_random();
    load_s();
    model_pass();
    run_pass("random");

    check("s_wren/dec_wren overlap", overlap_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
